// File: rtl/sd_init_sequencer_pkg.sv
// Shared definitions for the SDIO init sequencer: command indices, fail codes,
// R4/R6 field positions and the FSM/step encodings.
package sd_init_sequencer_pkg;

  localparam logic [5:0] CMD0 = 6'd0;
  localparam logic [5:0] CMD3 = 6'd3;
  localparam logic [5:0] CMD5 = 6'd5;
  localparam logic [5:0] CMD7 = 6'd7;

  localparam logic [3:0] FAIL_NONE     = 4'd0;
  localparam logic [3:0] FAIL_NO_CARD  = 4'd1;
  localparam logic [3:0] FAIL_TIMEOUT  = 4'd2;
  localparam logic [3:0] FAIL_STACK    = 4'd3;
  localparam logic [3:0] FAIL_VOLTAGE  = 4'd4;
  localparam logic [3:0] FAIL_RETRIES  = 4'd5;
  localparam logic [3:0] FAIL_RCA_ZERO = 4'd6;

  localparam int R4_READY_BIT = 31;
  localparam int R4_FUNCS_MSB = 30;
  localparam int R4_FUNCS_LSB = 28;
  localparam int R4_MEM_BIT   = 27;
  localparam int R4_OCR_MSB   = 23;
  localparam int R6_RCA_MSB   = 31;
  localparam int R6_RCA_LSB   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RETRY_DLY,
    ST_DONE,
    ST_FAIL
  } state_t;

  typedef enum logic [2:0] {
    STEP_CMD0,
    STEP_CMD5P,
    STEP_CMD5S,
    STEP_CMD3,
    STEP_CMD7
  } step_t;

  function automatic logic [5:0] step_cmd(input step_t step);
    case (step)
      STEP_CMD0:              return CMD0;
      STEP_CMD5P, STEP_CMD5S: return CMD5;
      STEP_CMD3:              return CMD3;
      default:                return CMD7;
    endcase
  endfunction

  // The timer flags zero one load-value after loading, so an N-cycle window loads N-1.
  function automatic logic [31:0] cycles_to_load(input logic [31:0] cycles);
    return (cycles == 32'd0) ? 32'd0 : cycles - 32'd1;
  endfunction

endpackage

// File: rtl/sd_init_timer.sv
// Loadable 32-bit down-counter with a zero flag; shared by the response
// timeout and the CMD5 retry delay.
module sd_init_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        dec,
  output logic        zero
);

  logic [31:0] count;

  // Load wins over decrement; the count holds at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  assign zero = (count == 32'd0);

endmodule

// File: rtl/sd_init_sequencer.sv
// Brings an SDIO card from power-up to the transfer state via
// CMD0 -> CMD5 probe -> CMD5 set (retried) -> CMD3 -> CMD7.
module sd_init_sequencer
  import sd_init_sequencer_pkg::*;
#(
  parameter logic [23:0] OCR_VOLTAGE = 24'h300000,
  parameter logic [15:0] MAX_RETRIES = 16'd1000,
  parameter logic [31:0] RETRY_DELAY = 32'd10000,
  parameter logic [31:0] RSP_TIMEOUT = 32'd500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_card_detect,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_fail,
  output logic [3:0]   o_fail_code,
  output logic [15:0]  o_rca,
  output logic [23:0]  o_ocr,
  output logic [2:0]   o_num_funcs,
  output logic         o_mem_present,
  output logic         o_cmd_en,
  output logic [5:0]   o_cmd,
  output logic [31:0]  o_cmd_arg,
  output logic         o_rsp_long_flag,
  input  logic         i_sd_ready,
  input  logic         i_cmd_finished_en,
  input  logic [127:0] i_rsp,
  input  logic         i_error_flag
);

  state_t      state;
  step_t       step;
  logic [15:0] retry_count;
  logic [15:0] retry_next;
  logic        timer_load;
  logic        timer_dec;
  logic [31:0] timer_value;
  logic        timer_zero;
  logic        unused_rsp_bits;

  assign o_rsp_long_flag = 1'b0;
  assign unused_rsp_bits = ^{i_rsp[127:32], i_rsp[26:24]};
  assign retry_next      = (retry_count == 16'hFFFF) ? retry_count : retry_count + 16'd1;

  // The timeout is armed every cycle spent in ISSUE so it is fresh when the
  // strobe goes out; any finish in WAIT arms the retry delay, which only
  // matters if the next state is RETRY_DLY.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = cycles_to_load(RSP_TIMEOUT);
    if (state == ST_ISSUE) begin
      timer_load = 1'b1;
    end else if (state == ST_WAIT && i_cmd_finished_en) begin
      timer_load  = 1'b1;
      timer_value = cycles_to_load(RETRY_DELAY);
    end
  end

  assign timer_dec = (state == ST_WAIT) || (state == ST_RETRY_DLY);

  sd_init_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  task automatic enter_fail(input logic [3:0] code);
    o_fail      <= 1'b1;
    o_fail_code <= code;
    o_busy      <= 1'b0;
    state       <= ST_FAIL;
  endtask

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      step          <= STEP_CMD0;
      retry_count   <= 16'd0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_fail        <= 1'b0;
      o_fail_code   <= FAIL_NONE;
      o_rca         <= 16'd0;
      o_ocr         <= 24'd0;
      o_num_funcs   <= 3'd0;
      o_mem_present <= 1'b0;
      o_cmd_en      <= 1'b0;
      o_cmd         <= 6'd0;
      o_cmd_arg     <= 32'd0;
    end else begin
      o_cmd_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (i_start) begin
            o_done        <= 1'b0;
            o_fail        <= 1'b0;
            o_fail_code   <= FAIL_NONE;
            o_rca         <= 16'd0;
            o_ocr         <= 24'd0;
            o_num_funcs   <= 3'd0;
            o_mem_present <= 1'b0;
            retry_count   <= 16'd0;
            step          <= STEP_CMD0;
            if (!i_card_detect) begin
              enter_fail(FAIL_NO_CARD);
            end else begin
              o_busy <= 1'b1;
              state  <= ST_ISSUE;
            end
          end
        end
        default: begin
          // Card removal outranks everything else while busy.
          if (!i_card_detect) begin
            enter_fail(FAIL_NO_CARD);
          end else begin
            case (state)
              ST_ISSUE: begin
                if (i_sd_ready) begin
                  o_cmd    <= step_cmd(step);
                  o_cmd_en <= 1'b1;
                  state    <= ST_WAIT;
                  case (step)
                    STEP_CMD5S: o_cmd_arg <= {8'h00, OCR_VOLTAGE};
                    STEP_CMD7:  o_cmd_arg <= {o_rca, 16'h0000};
                    default:    o_cmd_arg <= 32'd0;
                  endcase
                end
              end
              ST_WAIT: begin
                if (i_cmd_finished_en) begin
                  if (i_error_flag && step != STEP_CMD0) begin
                    enter_fail(FAIL_STACK);
                  end else begin
                    case (step)
                      STEP_CMD0: begin
                        step  <= STEP_CMD5P;
                        state <= ST_ISSUE;
                      end
                      STEP_CMD5P, STEP_CMD5S: begin
                        o_ocr         <= i_rsp[R4_OCR_MSB:0];
                        o_num_funcs   <= i_rsp[R4_FUNCS_MSB:R4_FUNCS_LSB];
                        o_mem_present <= i_rsp[R4_MEM_BIT];
                        if (step == STEP_CMD5P) begin
                          if ((i_rsp[R4_OCR_MSB:0] & OCR_VOLTAGE) == 24'd0) begin
                            enter_fail(FAIL_VOLTAGE);
                          end else begin
                            step        <= STEP_CMD5S;
                            retry_count <= 16'd0;
                            state       <= ST_ISSUE;
                          end
                        end else if (i_rsp[R4_READY_BIT]) begin
                          step  <= STEP_CMD3;
                          state <= ST_ISSUE;
                        end else if (retry_next >= MAX_RETRIES) begin
                          retry_count <= retry_next;
                          enter_fail(FAIL_RETRIES);
                        end else begin
                          retry_count <= retry_next;
                          state       <= ST_RETRY_DLY;
                        end
                      end
                      STEP_CMD3: begin
                        o_rca <= i_rsp[R6_RCA_MSB:R6_RCA_LSB];
                        if (i_rsp[R6_RCA_MSB:R6_RCA_LSB] == 16'd0) begin
                          enter_fail(FAIL_RCA_ZERO);
                        end else begin
                          step  <= STEP_CMD7;
                          state <= ST_ISSUE;
                        end
                      end
                      default: begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= ST_DONE;
                      end
                    endcase
                  end
                end else if (timer_zero) begin
                  enter_fail(FAIL_TIMEOUT);
                end
              end
              ST_RETRY_DLY: begin
                if (timer_zero) begin
                  state <= ST_ISSUE;
                end
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Scoreboard bench for sd_init_sequencer: a card responder plus a
// high-level reference model that predicts the command stream and outcome.
module tb_sd_init_sequencer;

  localparam logic [23:0] OCRV = 24'h300000;
  localparam int MAXR = 4;
  localparam int RDLY = 12;
  localparam int RTO  = 60;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_card_detect = 1'b1;
  logic         o_busy, o_done, o_fail;
  logic [3:0]   o_fail_code;
  logic [15:0]  o_rca;
  logic [23:0]  o_ocr;
  logic [2:0]   o_num_funcs;
  logic         o_mem_present;
  logic         o_cmd_en;
  logic [5:0]   o_cmd;
  logic [31:0]  o_cmd_arg;
  logic         o_rsp_long_flag;
  logic         i_sd_ready = 1'b0;
  logic         i_cmd_finished_en = 1'b0;
  logic [127:0] i_rsp = '0;
  logic         i_error_flag = 1'b0;

  always #5 clk = ~clk;

  sd_init_sequencer #(
    .OCR_VOLTAGE (OCRV),
    .MAX_RETRIES (16'(MAXR)),
    .RETRY_DELAY (32'(RDLY)),
    .RSP_TIMEOUT (32'(RTO))
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_start           (i_start),
    .i_card_detect     (i_card_detect),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_fail            (o_fail),
    .o_fail_code       (o_fail_code),
    .o_rca             (o_rca),
    .o_ocr             (o_ocr),
    .o_num_funcs       (o_num_funcs),
    .o_mem_present     (o_mem_present),
    .o_cmd_en          (o_cmd_en),
    .o_cmd             (o_cmd),
    .o_cmd_arg         (o_cmd_arg),
    .o_rsp_long_flag   (o_rsp_long_flag),
    .i_sd_ready        (i_sd_ready),
    .i_cmd_finished_en (i_cmd_finished_en),
    .i_rsp             (i_rsp),
    .i_error_flag      (i_error_flag)
  );

  // Card behaviour for one run; *_step is -1 or 0..4 (CMD0, CMD5P, CMD5S, CMD3, CMD7).
  typedef struct {
    bit        card;
    bit [23:0] ocr_p;
    bit [23:0] ocr_s;
    bit [2:0]  funcs;
    bit        mem;
    int        not_ready;
    bit [15:0] rca;
    int        pull_step;
    int        silent_step;
    int        err_step;
  } scen_t;

  typedef struct {
    bit        is_end;
    bit [5:0]  cmd;
    bit [31:0] arg;
    bit        done;
    bit        fail;
    bit [3:0]  code;
    bit [15:0] rca;
    bit [23:0] ocr;
    bit [2:0]  funcs;
    bit        mem;
    int        latency;
  } exp_t;

  exp_t  exp_q[$];
  scen_t sc;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_strobe = 0;
  int    strobes_seen = 0;
  int    cmd5_seen = 0;
  bit    last_was_5s = 0;
  bit    armed = 0;
  bit    mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int fault(input scen_t s, input int step);
    if (s.pull_step == step) return 1;
    if (s.silent_step == step) return 2;
    if (s.err_step == step && step != 0) return 3;
    return 0;
  endfunction

  task automatic push_cmd(input bit [5:0] cmd, input bit [31:0] arg);
    exp_t e;
    e = '{default: 0};
    e.cmd = cmd;
    e.arg = arg;
    exp_q.push_back(e);
  endtask

  // Reference model: walk the command sequence and predict strobes plus the final outcome.
  task automatic model(input scen_t s);
    exp_t      e;
    int        code = 0;
    bit [23:0] ocr = 0;
    bit [2:0]  funcs = 0;
    bit        mem = 0;
    bit [15:0] rca = 0;
    if (!s.card) begin
      code = 1;
    end else begin
      push_cmd(6'd0, 32'd0);
      code = fault(s, 0);
      if (code == 0) begin
        push_cmd(6'd5, 32'd0);
        code = fault(s, 1);
        if (code == 0) begin
          ocr = s.ocr_p; funcs = s.funcs; mem = s.mem;
          if ((s.ocr_p & OCRV) == 0) code = 4;
        end
      end
      if (code == 0) begin
        for (int a = 0; a < MAXR; a++) begin
          push_cmd(6'd5, {8'h00, OCRV});
          if (a == 0) code = fault(s, 2);
          if (code != 0) break;
          ocr = s.ocr_s; funcs = s.funcs; mem = s.mem;
          if (a >= s.not_ready) break;
          if (a + 1 >= MAXR) begin
            code = 5;
            break;
          end
        end
      end
      if (code == 0) begin
        push_cmd(6'd3, 32'd0);
        code = fault(s, 3);
        if (code == 0) begin
          rca = s.rca;
          if (rca == 0) code = 6;
        end
      end
      if (code == 0) begin
        push_cmd(6'd7, {rca, 16'h0000});
        code = fault(s, 4);
      end
    end
    e = '{default: 0};
    e.is_end  = 1;
    e.done    = (code == 0);
    e.fail    = (code != 0);
    e.code    = 4'(code);
    e.rca     = rca;
    e.ocr     = ocr;
    e.funcs   = funcs;
    e.mem     = mem;
    e.latency = (code == 2) ? RTO : -1;
    exp_q.push_back(e);
  endtask

  // Stack readiness wanders randomly.
  initial forever begin
    @(negedge clk);
    i_sd_ready = ($urandom % 4) != 0;
  end

  // Card/stack responder: answers each strobe after a random delay, or misbehaves as scripted.
  initial forever begin
    int        step;
    int        attempt;
    bit        first;
    bit [31:0] r;
    @(negedge clk);
    if (rst_n && o_cmd_en) begin
      attempt = 0;
      case (o_cmd)
        6'd0: step = 0;
        6'd5: begin
          if (cmd5_seen == 0) step = 1;
          else begin
            step = 2;
            attempt = cmd5_seen - 1;
          end
          cmd5_seen++;
        end
        6'd3: step = 3;
        default: step = 4;
      endcase
      first = (step != 2) || (attempt == 0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if (first && sc.pull_step == step) begin
        i_card_detect = 1'b0;
      end else if (!(first && sc.silent_step == step)) begin
        case (step)
          1: r = {1'($urandom), sc.funcs, sc.mem, 3'($urandom), sc.ocr_p};
          2: r = {(attempt >= sc.not_ready), sc.funcs, sc.mem, 3'($urandom), sc.ocr_s};
          3: r = {sc.rca, 16'($urandom)};
          default: r = $urandom;
        endcase
        i_rsp             = {$urandom, $urandom, $urandom, r};
        i_error_flag      = first && (sc.err_step == step);
        i_cmd_finished_en = 1'b1;
        @(negedge clk);
        i_cmd_finished_en = 1'b0;
        i_error_flag      = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe and on each run's completion.
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (mon_en && rst_n) begin
      if (armed && (o_done || o_fail)) begin
        armed = 0;
        check("end_expected", 64'(exp_q.size() != 0 && exp_q[0].is_end), 64'd1);
        if (exp_q.size() != 0 && exp_q[0].is_end) begin
          e = exp_q.pop_front();
          check("done", o_done, e.done);
          check("fail", o_fail, e.fail);
          check("fail_code", o_fail_code, e.code);
          check("busy_at_end", o_busy, 0);
          check("rca", o_rca, e.rca);
          check("ocr", o_ocr, e.ocr);
          check("num_funcs", o_num_funcs, e.funcs);
          check("mem_present", o_mem_present, e.mem);
          if (e.latency >= 0) check("timeout_latency", 64'(cyc - last_strobe), 64'(e.latency));
        end
      end
      if (o_cmd_en) begin
        strobes_seen++;
        check("strobe_expected", 64'(exp_q.size() != 0 && !exp_q[0].is_end), 64'd1);
        check("rsp_long_flag", o_rsp_long_flag, 0);
        if (exp_q.size() != 0 && !exp_q[0].is_end) begin
          e = exp_q.pop_front();
          check("cmd_index", o_cmd, e.cmd);
          check("cmd_arg", o_cmd_arg, e.arg);
        end
        if (o_cmd == 6'd5 && o_cmd_arg != 32'd0) begin
          if (last_was_5s) check("retry_gap_ok", 64'((cyc - last_strobe) >= RDLY), 64'd1);
          last_was_5s = 1;
        end else begin
          last_was_5s = 0;
        end
        last_strobe = cyc;
      end
      if (i_start) armed = 1;
    end
  end

  function automatic scen_t normal_scen();
    scen_t s;
    s.card = 1; s.ocr_p = 24'hFF8000; s.ocr_s = 24'hFF8000;
    s.funcs = 3'd1; s.mem = 0; s.not_ready = 0; s.rca = 16'hBEEF;
    s.pull_step = -1; s.silent_step = -1; s.err_step = -1;
    return s;
  endfunction

  function automatic scen_t random_scen();
    scen_t s;
    int    kind;
    s = normal_scen();
    s.card = ($urandom % 8) != 0;
    s.ocr_p = 24'($urandom);
    if ($urandom % 4 == 0) s.ocr_p = s.ocr_p & ~OCRV;
    s.ocr_s = 24'($urandom);
    s.funcs = 3'($urandom);
    s.mem = 1'($urandom);
    s.not_ready = $urandom_range(0, MAXR);
    s.rca = ($urandom % 5 == 0) ? 16'd0 : 16'($urandom);
    kind = $urandom_range(0, 5);
    if (kind == 1) s.pull_step = $urandom_range(0, 4);
    if (kind == 2) s.silent_step = $urandom_range(0, 4);
    if (kind == 3) s.err_step = $urandom_range(0, 4);
    return s;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_fail"}, o_fail, 0);
    check({tag, "_code"}, o_fail_code, 0);
    check({tag, "_rca"}, o_rca, 0);
    check({tag, "_ocr"}, o_ocr, 0);
    check({tag, "_funcs_mem"}, {o_num_funcs, o_mem_present}, 0);
    check({tag, "_cmd_en"}, o_cmd_en, 0);
    check({tag, "_cmd"}, o_cmd, 0);
    check({tag, "_cmd_arg"}, o_cmd_arg, 0);
  endtask

  task automatic applyStimulus(input scen_t s, input bit mid_start);
    int guard;
    sc = s;
    cmd5_seen = 0;
    last_was_5s = 0;
    strobes_seen = 0;
    i_card_detect = s.card;
    model(s);
    pulse_start();
    if (mid_start) begin
      guard = 0;
      while (strobes_seen < 2 && guard < 2000) begin
        @(posedge clk);
        guard++;
      end
      #1 i_start = 1'b1;
      @(posedge clk); #1 i_start = 1'b0;
    end
    guard = 0;
    while (armed && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    checkOutput();
  endtask

  task automatic checkOutput();
    check("run_completed", armed, 0);
    check("queue_drained", exp_q.size(), 0);
    armed = 0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1 i_card_detect = 1'b1;
  endtask

  initial begin
    scen_t s;
    int    guard;
    bit    saw_strobe;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;
    repeat (2) @(negedge clk);

    applyStimulus(normal_scen(), 0);
    s = normal_scen(); s.not_ready = 2;
    applyStimulus(s, 0);
    s = normal_scen(); s.silent_step = 3;
    applyStimulus(s, 0);
    s = normal_scen(); s.ocr_p = 24'h000080;
    applyStimulus(s, 0);
    s = normal_scen(); s.err_step = 3;
    applyStimulus(s, 0);
    s = normal_scen(); s.pull_step = 2;
    applyStimulus(s, 0);
    s = normal_scen(); s.card = 0;
    applyStimulus(s, 0);
    s = normal_scen(); s.not_ready = MAXR;
    applyStimulus(s, 0);
    s = normal_scen(); s.rca = 16'd0;
    applyStimulus(s, 0);
    s = normal_scen(); s.err_step = 0;
    applyStimulus(s, 0);
    applyStimulus(normal_scen(), 1);

    // Asynchronous reset in the middle of a WAIT.
    mon_en = 0;
    sc = normal_scen();
    cmd5_seen = 0;
    pulse_start();
    guard = 0;
    while (!o_cmd_en && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    saw_strobe = o_cmd_en;
    check("reset_test_strobe_seen", saw_strobe, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    armed = 0;
    exp_q.delete();
    mon_en = 1;
    repeat (2) @(negedge clk);

    applyStimulus(normal_scen(), 0);
    for (int n = 0; n < 14; n++) begin
      applyStimulus(random_scen(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
